// File: rtl/density_phase_scheduler_pkg.sv
// Shared definitions for the density-driven traffic phase scheduler:
// phase encoding, lane geometry and default timing.
package density_phase_scheduler_pkg;

    typedef enum logic [1:0] {
        PH_ALLRED = 2'd0,
        PH_GREEN  = 2'd1,
        PH_AMBER  = 2'd2
    } phase_t;

    localparam int NUM_LANES = 4;
    localparam int CNT_W     = 8;

    localparam int DEF_G_BASE  = 8;
    localparam int DEF_G_EXT   = 4;
    localparam int DEF_G_MIN   = 4;
    localparam int DEF_AMBER_T = 3;
    localparam int DEF_RED_T   = 2;

endpackage

// File: rtl/density_phase_scheduler_lane_pick.sv
// Round-robin next-lane search: first lane with nonzero density, scanning
// from START (inclusive) or START+1 (exclusive, START itself checked last).
module lane_pick
    import density_phase_scheduler_pkg::*;
(
    input  logic [7:0] DENS,
    input  logic [1:0] START,
    input  logic       INCL,
    output logic [1:0] LANE,
    output logic       FOUND
);

    logic [NUM_LANES-1:0] busy;
    logic [1:0]           cand;

    generate
        for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_busy
            assign busy[gi] = |DENS[2*gi +: 2];
        end
    endgenerate

    // Scan from the farthest offset down so the nearest busy lane wins.
    always_comb begin
        LANE  = START + {1'b0, ~INCL};
        FOUND = 1'b0;
        cand  = 2'd0;
        for (int i = NUM_LANES - 1; i >= 0; i--) begin
            cand = START + 2'(i) + {1'b0, ~INCL};
            if (busy[cand]) begin
                LANE  = cand;
                FOUND = 1'b1;
            end
        end
    end

endmodule

// File: rtl/density_phase_scheduler.sv
// Three-phase lane scheduler: density-scaled green, fixed amber, all-red
// clearance, round-robin lane rotation with early exit when demand vanishes.
module density_phase_scheduler
    import density_phase_scheduler_pkg::*;
#(
    parameter int G_BASE  = DEF_G_BASE,
    parameter int G_EXT   = DEF_G_EXT,
    parameter int G_MIN   = DEF_G_MIN,
    parameter int AMBER_T = DEF_AMBER_T,
    parameter int RED_T   = DEF_RED_T
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [7:0] DENS,
    output logic [1:0] SEL,
    output logic       GREEN_EN,
    output logic       AMBER_EN,
    output logic [1:0] PHASE
);

    if (G_BASE + 3 * G_EXT > 255) begin : g_len_check
        $error("G_BASE + 3*G_EXT must not exceed 255");
    end
    if (G_MIN < 1 || G_MIN > G_BASE || AMBER_T < 1 || RED_T < 1) begin : g_timing_check
        $error("timing parameters out of range");
    end

    localparam logic [CNT_W-1:0] BASE_L  = CNT_W'(G_BASE);
    localparam logic [CNT_W-1:0] EXT_L   = CNT_W'(G_EXT);
    localparam logic [CNT_W-1:0] G_MIN_L = CNT_W'(G_MIN);
    localparam logic [CNT_W-1:0] AMBER_L = CNT_W'(AMBER_T);
    localparam logic [CNT_W-1:0] RED_L   = CNT_W'(RED_T);

    phase_t           phase_q, phase_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] elapsed_q, elapsed_d;
    logic [1:0]       sel_q, sel_d;
    logic             first_q, first_d;
    logic             demand_q, demand_d;
    logic             green_q, green_d;
    logic             amber_q, amber_d;

    logic [1:0]       pick_lane;
    logic             pick_found;
    logic [1:0]       pick_dens;
    logic [1:0]       sel_dens;
    logic [CNT_W-1:0] green_len;
    logic             early_exit;

    lane_pick u_lane_pick (
        .DENS  (DENS),
        .START (sel_q),
        .INCL  (first_q),
        .LANE  (pick_lane),
        .FOUND (pick_found)
    );

    assign pick_dens = DENS[2*pick_lane +: 2];
    assign sel_dens  = DENS[2*sel_q +: 2];
    assign green_len = BASE_L + EXT_L * {6'd0, pick_dens};

    // Early exit only applies to a grant made for real demand; a fallback
    // grant to an empty lane always runs its full base length.
    assign early_exit = demand_q && (elapsed_q >= G_MIN_L) && (sel_dens == 2'd0);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            phase_q   <= PH_ALLRED;
            cnt_q     <= RED_L;
            elapsed_q <= '0;
            sel_q     <= 2'd0;
            first_q   <= 1'b1;
            demand_q  <= 1'b0;
            green_q   <= 1'b0;
            amber_q   <= 1'b0;
        end else begin
            phase_q   <= phase_d;
            cnt_q     <= cnt_d;
            elapsed_q <= elapsed_d;
            sel_q     <= sel_d;
            first_q   <= first_d;
            demand_q  <= demand_d;
            green_q   <= green_d;
            amber_q   <= amber_d;
        end
    end

    always_comb begin
        phase_d   = phase_q;
        cnt_d     = cnt_q;
        elapsed_d = elapsed_q;
        sel_d     = sel_q;
        first_d   = first_q;
        demand_d  = demand_q;
        case (phase_q)
            PH_ALLRED: begin
                if (cnt_q <= 8'd1) begin
                    phase_d   = PH_GREEN;
                    sel_d     = pick_lane;
                    first_d   = 1'b0;
                    demand_d  = pick_found;
                    cnt_d     = green_len;
                    elapsed_d = 8'd1;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            PH_GREEN: begin
                if (cnt_q <= 8'd1 || early_exit) begin
                    phase_d = PH_AMBER;
                    cnt_d   = AMBER_L;
                end else begin
                    cnt_d     = cnt_q - 8'd1;
                    elapsed_d = elapsed_q + 8'd1;
                end
            end
            PH_AMBER: begin
                if (cnt_q <= 8'd1) begin
                    phase_d = PH_ALLRED;
                    cnt_d   = RED_L;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: begin
                phase_d = PH_ALLRED;
                cnt_d   = RED_L;
            end
        endcase
        green_d = (phase_d == PH_GREEN);
        amber_d = (phase_d == PH_AMBER);
    end

    assign SEL      = sel_q;
    assign GREEN_EN = green_q;
    assign AMBER_EN = amber_q;
    assign PHASE    = phase_q;

endmodule
